// File: rtl/axi_mem_responder.sv
// Single-port AXI-style burst memory: fixed 8-beat x 64-bit line bursts,
// read and write serialized through one FSM, sticky wlast-mismatch flag.
module axi_mem_responder #(
  parameter int MEM_WORDS    = 512,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] m_axi_araddr,
  input  logic        m_axi_arvalid,
  output logic        m_axi_arready,
  output logic [63:0] m_axi_rdata,
  output logic        m_axi_rvalid,
  output logic        m_axi_rlast,
  input  logic        m_axi_rready,
  input  logic [63:0] m_axi_awaddr,
  input  logic        m_axi_awvalid,
  output logic        m_axi_awready,
  input  logic [63:0] m_axi_wdata,
  input  logic        m_axi_wvalid,
  input  logic        m_axi_wlast,
  output logic        m_axi_wready,
  output logic        m_axi_bvalid,
  input  logic        m_axi_bready,
  output logic        protocol_err
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = AW - 3;

  typedef enum logic [2:0] {IDLE, R_WAIT, R_DATA, W_DATA, W_RESP} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   line_q, line_d;
  logic [2:0]      beat_q, beat_d;
  logic [3:0]      lat_q, lat_d;
  logic            perr_q, perr_d;
  logic            mem_we;
  logic [AW-1:0]   word;
  logic [63:0]     mem [MEM_WORDS];

  // Line index occupies the upper address bits, beat the lower three: wraps naturally.
  assign word = {line_q, beat_q};

  logic unused_addr;
  assign unused_addr = ^{m_axi_araddr[5:0], m_axi_araddr[63:6+LW],
                         m_axi_awaddr[5:0], m_axi_awaddr[63:6+LW]};

  always_comb begin
    state_d       = state_q;
    line_d        = line_q;
    beat_d        = beat_q;
    lat_d         = lat_q;
    perr_d        = perr_q;
    mem_we        = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_awready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rvalid  = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        m_axi_awready = 1'b1;
        // Write wins so a dirty-line writeback lands before the refill read.
        m_axi_arready = !m_axi_awvalid;
        if (m_axi_awvalid) begin
          line_d  = m_axi_awaddr[6 +: LW];
          beat_d  = 3'd0;
          state_d = W_DATA;
        end else if (m_axi_arvalid) begin
          line_d  = m_axi_araddr[6 +: LW];
          beat_d  = 3'd0;
          lat_d   = 4'(READ_LATENCY);
          state_d = (READ_LATENCY > 0) ? R_WAIT : R_DATA;
        end
      end
      R_WAIT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q <= 4'd1) state_d = R_DATA;
      end
      R_DATA: begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem[word];
        m_axi_rlast  = (beat_q == 3'd7);
        if (m_axi_rready) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = IDLE;
        end
      end
      W_DATA: begin
        m_axi_wready = 1'b1;
        if (m_axi_wvalid) begin
          mem_we = 1'b1;
          if (m_axi_wlast != (beat_q == 3'd7)) perr_d = 1'b1;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = W_RESP;
        end
      end
      W_RESP: begin
        m_axi_bvalid = 1'b1;
        if (m_axi_bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      perr_q  <= perr_d;
    end
  end

  // Storage is never reset; a write completed before reset stays put.
  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[word] <= m_axi_wdata;
  end

  assign protocol_err = perr_q;
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 512, number of 64-bit storage words (power of 2, multiple of 8).
REQ-002 SHALL have parameter READ_LATENCY, default 2, idle cycles between AR handshake and first rvalid (0..15).
REQ-003 SHALL have one clock and synchronous active-low reset; ports listed below, clock and reset first.
REQ-004 clk  input  1  sole clock, all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 m_axi_araddr  input  64  read burst byte address; bits [5:0] ignored.
REQ-007 m_axi_arvalid  input  1  read address valid.
REQ-008 m_axi_arready  output  1  read address accepted.
REQ-009 m_axi_rdata  output  64  read beat data.
REQ-010 m_axi_rvalid  output  1  read beat valid.
REQ-011 m_axi_rlast  output  1  final (8th) read beat.
REQ-012 m_axi_rready  input  1  master accepts read beat.
REQ-013 m_axi_awaddr  input  64  write burst byte address; bits [5:0] ignored.
REQ-014 m_axi_awvalid  input  1  write address valid.
REQ-015 m_axi_awready  output  1  write address accepted.
REQ-016 m_axi_wdata  input  64  write beat data.
REQ-017 m_axi_wvalid  input  1  write beat valid.
REQ-018 m_axi_wlast  input  1  master-flagged final write beat.
REQ-019 m_axi_wready  output  1  write beat accepted.
REQ-020 m_axi_bvalid  output  1  write response valid.
REQ-021 m_axi_bready  input  1  master accepts write response.
REQ-022 protocol_err  output  1  sticky: wlast mismatch seen.

Function
REQ-023 Every burst SHALL be exactly 8 beats of 64 bits (one 64-byte line); beat i maps to word index ((addr>>6)*8 + i) mod MEM_WORDS.
REQ-024 Beat 0 SHALL be the lowest-addressed word of the line (the master places beat i at line bits [64i+63:64i]).
REQ-025 Handshake SHALL complete in a cycle where valid and ready are both 1 at the rising edge.
REQ-026 States SHALL be IDLE, R_WAIT, R_DATA, W_DATA, W_RESP; one burst in flight at a time, read and write serialized.
REQ-027 IDLE: awready=1; arready = !awvalid (write wins when both valid, so a dirty-line writeback precedes the refill read); all other outputs 0.
REQ-028 IDLE, AW handshake: latch line address, beat counter=0, -> W_DATA.
REQ-029 IDLE, AR handshake (no awvalid): latch line address, beat counter=0, latency counter=READ_LATENCY, -> R_WAIT if READ_LATENCY>0 else R_DATA.
REQ-030 R_WAIT: all outputs 0; decrement latency counter each cycle; -> R_DATA the cycle it reaches 1.
REQ-031 R_DATA: rvalid=1, rdata=mem[word(beat)], rlast=(beat==7); rdata/rlast SHALL hold stable while rready=0.
REQ-032 R_DATA, rready=1: beat+1; on beat 7 -> IDLE; no rvalid gap between beats.
REQ-033 W_DATA: wready=1; on wvalid, mem[word(beat)] <= wdata at that edge, beat+1; after beat 7 -> W_RESP.
REQ-034 W_DATA: wlast=1 on beat<7, or wlast=0 on beat 7, SHALL set protocol_err; burst length stays 8 regardless of wlast.
REQ-035 W_RESP: bvalid=1 until bready=1, then -> IDLE next cycle.
REQ-036 arready, awready SHALL be 0 outside IDLE; requests held valid are accepted on return to IDLE.
REQ-037 Write data SHALL be visible to any read burst accepted after the write's B handshake.
REQ-038 Beat counter 3 bits, latency counter 4 bits; address wraps modulo MEM_WORDS, no out-of-range error.

Reset
REQ-039 reset=0 at a rising edge SHALL force IDLE, clear beat/latency counters and protocol_err; all outputs except arready/awready read 0 in the following cycle.
REQ-040 Reset mid-burst SHALL abort the burst with no response; words already written stay written; memory array is not cleared by reset.
REQ-041 Memory contents after power-up are undefined until written.

Verification
REQ-042 Write burst to 0x1000, data 0xA0..0xA7, bready=1 -> 8 wready beats, bvalid one cycle later; read 0x1000, READ_LATENCY=2 -> first rvalid 3 cycles after AR handshake, rdata 0xA0..0xA7, rlast on 0xA7 only.
REQ-043 awvalid and arvalid raised same cycle (write 0x2000 = 0xB0..0xB7, read 0x2000) -> AW accepted first, arready=0 that cycle; read returns 0xB0..0xB7.
REQ-044 Read with rready toggling 1,0,0,1,... -> rdata/rlast held during stalls; 8 beats delivered in order, no beat dropped or duplicated.
REQ-045 Write with wlast asserted on beat 5 -> protocol_err=1 and stays 1; beats 6,7 still accepted; bvalid after beat 7.
REQ-046 Reset asserted on read beat 3 -> next cycle rvalid=0, arready=1; new read of same line returns full 8 beats from beat 0.
REQ-047 Write to 0x1000 with MEM_WORDS=512 then read 0x2000_1000 -> same data returned (address wrap).
